// File: rtl/symbol_packer.sv
// symbol_packer: packs a stream of SIZE_DATA_IN-bit symbols into
// SIZE_DATA_OUT-bit words, symbol 0 in the LSBs. A one-word output holding
// register lets assembly of the next word proceed while the previous word
// waits for the downstream side. i_flush emits a zero-padded partial word.
module symbol_packer #(
  parameter int SIZE_DATA_IN  = 2,
  parameter int SIZE_DATA_OUT = 16,
  // Derived; SIZE_DATA_OUT must be an integer multiple of SIZE_DATA_IN.
  localparam int DEPTH = SIZE_DATA_OUT / SIZE_DATA_IN,
  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LEN_W = $clog2(DEPTH) + 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_valid,
  input  logic [SIZE_DATA_IN-1:0]  i_data,
  output logic                     o_ready,
  input  logic                     i_flush,
  output logic                     o_valid,
  output logic [SIZE_DATA_OUT-1:0] o_data,
  output logic [LEN_W-1:0]         o_len,
  input  logic                     i_ready
);

  // Assembly state
  logic [SIZE_DATA_OUT-1:0] r_acc;
  logic [CNT_W-1:0]         r_cnt;

  // Output holding register
  logic [SIZE_DATA_OUT-1:0] r_obuf;
  logic [LEN_W-1:0]         r_olen;
  logic                     r_ofull;

  logic                     w_slot;
  logic                     w_last;
  logic                     w_accept;
  logic                     w_complete;
  logic                     w_flush;
  logic                     w_load;
  logic [LEN_W-1:0]         w_n;
  logic [SIZE_DATA_OUT-1:0] w_merged;

  // The holding register can take a new word if empty or draining this cycle.
  assign w_slot = ~r_ofull | i_ready;
  assign w_last = (r_cnt == CNT_W'(DEPTH - 1));

  // Only the completing symbol needs a free output slot; earlier symbols of
  // the next word are accepted even while the held word is stalled.
  // Gated by reset so nothing looks accepted while reset is asserted.
  assign o_ready  = ~i_rst & i_start & (~w_last | w_slot);
  assign w_accept = i_start & i_valid & o_ready;

  assign w_complete = w_accept & w_last;

  // Effective symbol count including a symbol accepted this same cycle.
  assign w_n = LEN_W'(r_cnt) + LEN_W'(w_accept);

  // An empty flush (n==0) does nothing, so no zero-length word is ever emitted.
  assign w_flush = i_flush & i_start & w_slot & (w_n != '0);
  assign w_load  = w_complete | w_flush;

  // Accumulator with this cycle's accepted symbol merged into its slot.
  // Slots above cnt are always zero because acc clears on every load,
  // which provides the zero padding for flushed partial words.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign w_merged[gi*SIZE_DATA_IN +: SIZE_DATA_IN] =
        (w_accept && (r_cnt == CNT_W'(gi))) ? i_data
                                            : r_acc[gi*SIZE_DATA_IN +: SIZE_DATA_IN];
    end
  endgenerate

  // Assembly register and symbol counter; cleared when disabled or on a load.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (!i_start || w_load) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_acc <= w_merged;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Output holding register; a new word reloads ahead of a same-cycle drain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_obuf  <= '0;
      r_olen  <= '0;
      r_ofull <= 1'b0;
    end else if (w_load) begin
      r_obuf  <= w_merged;
      r_olen  <= w_n;
      r_ofull <= 1'b1;
    end else if (r_ofull && i_ready) begin
      r_ofull <= 1'b0;
    end
  end

  assign o_valid = r_ofull;
  assign o_data  = r_obuf;
  assign o_len   = r_olen;

endmodule

// File: tb/tb_symbol_packer.sv
// Directed bench for symbol_packer: a table of per-cycle input/expected-output
// records plus hand-written sequences for reset behaviour.
module tb_symbol_packer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        valid;
  logic [1:0]  data;
  logic        ordy;
  logic        flush;
  logic        ovld;
  logic [15:0] odata;
  logic [3:0]  olen;
  logic        irdy;

  int checks = 0;
  int errors = 0;

  symbol_packer #(.SIZE_DATA_IN(2), .SIZE_DATA_OUT(16)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_valid (valid),
    .i_data  (data),
    .o_ready (ordy),
    .i_flush (flush),
    .o_valid (ovld),
    .o_data  (odata),
    .o_len   (olen),
    .i_ready (irdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        valid;
    logic [1:0]  data;
    logic        flush;
    logic        rdy;
    logic        e_rdy;
    logic        e_vld;
    logic [15:0] e_data;
    logic [3:0]  e_len;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic s, input logic v, input logic [1:0] d,
                     input logic f, input logic r, input logic er,
                     input logic ev, input logic [15:0] ed, input logic [3:0] el);
    vec_t t;
    t.start = s; t.valid = v; t.data = d; t.flush = f; t.rdy = r;
    t.e_rdy = er; t.e_vld = ev; t.e_data = ed; t.e_len = el;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic v, input logic [1:0] d,
                       input logic f, input logic r);
    start = s; valid = v; data = d; flush = f; irdy = r;
  endtask

  // Advance to the next cycle: let the edge happen, then settle past it.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] bsym [8];
  logic [1:0] rsym [8];

  initial begin
    bsym = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2};   // packs to 16'hB1B1
    rsym = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3};   // packs to 16'hC009

    // Test 1: sequential packing 0,1,2,3,0,1,2,3 -> E4E4
    for (int i = 0; i < 8; i++) add(1, 1, 2'(i % 4), 0, 1, 1, 0, 16'h0, 4'd0);
    add(1, 0, 0, 0, 1, 1, 1, 16'hE4E4, 4'd8);
    add(1, 0, 0, 0, 1, 1, 0, 16'h0, 4'd0);

    // Test 2: backpressure; word A = FFFF held while next word assembles
    for (int i = 0; i < 8; i++) add(1, 1, 2'd3, 0, 1, 1, 0, 16'h0, 4'd0);
    for (int i = 0; i < 7; i++) add(1, 1, bsym[i], 0, 0, 1, 1, 16'hFFFF, 4'd8);
    add(1, 1, bsym[7], 0, 0, 0, 1, 16'hFFFF, 4'd8);
    add(1, 1, bsym[7], 0, 0, 0, 1, 16'hFFFF, 4'd8);
    add(1, 1, bsym[7], 0, 1, 1, 1, 16'hFFFF, 4'd8);
    add(1, 0, 0, 0, 1, 1, 1, 16'hB1B1, 4'd8);
    add(1, 0, 0, 0, 1, 1, 0, 16'h0, 4'd0);

    // Test 3: flush partial 1,2,3 + flush with 1 -> 0079 len 4; empty flush idle
    add(1, 1, 2'd1, 0, 1, 1, 0, 16'h0, 4'd0);
    add(1, 1, 2'd2, 0, 1, 1, 0, 16'h0, 4'd0);
    add(1, 1, 2'd3, 0, 1, 1, 0, 16'h0, 4'd0);
    add(1, 1, 2'd1, 1, 1, 1, 0, 16'h0, 4'd0);
    add(1, 0, 0, 0, 1, 1, 1, 16'h0079, 4'd4);
    add(1, 0, 0, 1, 1, 1, 0, 16'h0, 4'd0);
    add(1, 0, 0, 0, 1, 1, 0, 16'h0, 4'd0);

    // Test 4: flush on the 8th symbol -> single full word 1B1B
    for (int i = 0; i < 8; i++) add(1, 1, 2'(3 - (i % 4)), (i == 7), 1, 1, 0, 16'h0, 4'd0);
    add(1, 0, 0, 0, 1, 1, 1, 16'h1B1B, 4'd8);
    add(1, 0, 0, 0, 1, 1, 0, 16'h0, 4'd0);
    add(1, 0, 0, 0, 1, 1, 0, 16'h0, 4'd0);

    // Test 5: i_start drop discards 5-symbol partial; then AAAA
    for (int i = 0; i < 5; i++) add(1, 1, 2'd1, 0, 1, 1, 0, 16'h0, 4'd0);
    add(0, 1, 2'd1, 0, 1, 0, 0, 16'h0, 4'd0);
    for (int i = 0; i < 8; i++) add(1, 1, 2'd2, 0, 1, 1, 0, 16'h0, 4'd0);
    add(1, 0, 0, 0, 1, 1, 1, 16'hAAAA, 4'd8);
    add(1, 0, 0, 0, 1, 1, 0, 16'h0, 4'd0);

    // Reset
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (2) next_cycle();
    drive(1, 1, 2'd3, 0, 1);
    @(negedge clk);
    $display("reset   ordy=%b ovld=%b odata=%h olen=%0d", ordy, ovld, odata, olen);
    chk("reset_o_ready", 16'(ordy), 16'h0);
    chk("reset_o_valid", 16'(ovld), 16'h0);
    chk("reset_o_data", odata, 16'h0);
    chk("reset_o_len", 16'(olen), 16'h0);
    next_cycle();
    rst = 1'b0;

    // Table-driven vectors
    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].start, tbl[k].valid, tbl[k].data, tbl[k].flush, tbl[k].rdy);
      @(negedge clk);
      $display("vec %0d s=%b v=%b d=%0d f=%b r=%b -> ordy=%b ovld=%b odata=%h olen=%0d",
               k, start, valid, data, flush, irdy, ordy, ovld, odata, olen);
      chk($sformatf("vec%0d_o_ready", k), 16'(ordy), 16'(tbl[k].e_rdy));
      chk($sformatf("vec%0d_o_valid", k), 16'(ovld), 16'(tbl[k].e_vld));
      if (tbl[k].e_vld) begin
        chk($sformatf("vec%0d_o_data", k), odata, tbl[k].e_data);
        chk($sformatf("vec%0d_o_len", k), 16'(olen), 16'(tbl[k].e_len));
      end
      next_cycle();
    end

    // Mid-operation reset: word 5555 pending, cnt=3, then reset
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 2'd1, 0, 1);
      next_cycle();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 2'd3, 0, 0);
      next_cycle();
    end
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    $display("prerst  ovld=%b odata=%h olen=%0d", ovld, odata, olen);
    chk("prerst_o_valid", 16'(ovld), 16'h1);
    chk("prerst_o_data", odata, 16'h5555);
    next_cycle();
    rst = 1'b1;
    drive(1, 1, 2'd3, 0, 1);
    next_cycle();
    rst = 1'b0;
    drive(1, 0, 0, 0, 1);
    @(negedge clk);
    $display("postrst ovld=%b odata=%h olen=%0d", ovld, odata, olen);
    chk("postrst_o_valid", 16'(ovld), 16'h0);
    chk("postrst_o_len", 16'(olen), 16'h0);
    next_cycle();
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, rsym[i], 0, 1);
      next_cycle();
    end
    drive(1, 0, 0, 0, 1);
    @(negedge clk);
    $display("repack  ovld=%b odata=%h olen=%0d", ovld, odata, olen);
    chk("repack_o_valid", 16'(ovld), 16'h1);
    chk("repack_o_data", odata, 16'hC009);
    chk("repack_o_len", 16'(olen), 16'h8);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/symbol_packer.md
# symbol_packer

Collects a stream of SIZE_DATA_IN-bit symbols into SIZE_DATA_OUT-bit words. It is the inverse of the word-to-symbol splitter that feeds the decoder front end. It sits at the decoder output, where it packs decoded symbols back into bus words for the host-side buffer. It has a valid/ready handshake on both sides, a one-word output holding register so assembly continues while a word waits, and a flush that emits a zero-padded partial word.

## Interface
- SIZE_DATA_IN, 2, symbol width in bits.
- SIZE_DATA_OUT, 16, word width in bits; must be an integer multiple of SIZE_DATA_IN.
- DEPTH, SIZE_DATA_OUT/SIZE_DATA_IN (8), symbols per word; derived, not overridden.
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_start  in  1  enable; while low, no symbols are accepted and the partial word is discarded.
- i_valid  in  1  upstream symbol valid.
- i_data  in  SIZE_DATA_IN  symbol.
- o_ready  out  1  symbol accepted this cycle if i_valid & o_ready.
- i_flush  in  1  emit the current partial word; see Operation.
- o_valid  out  1  output word valid.
- o_data  out  SIZE_DATA_OUT  packed word.
- o_len  out  $clog2(DEPTH)+1  number of valid symbols in o_data (1..DEPTH).
- i_ready  in  1  downstream ready; the word transfers when o_valid & i_ready.

## Operation
- Assembly register acc[SIZE_DATA_OUT-1:0] with a symbol counter cnt (0..DEPTH-1).
- Output register obuf, olen, and a full flag ofull. o_data=obuf, o_len=olen, o_valid=ofull.
- Accept = i_start & i_valid & o_ready.
- Symbol k of a word goes to acc[k*SIZE_DATA_IN +: SIZE_DATA_IN]. Symbol 0 is in the LSBs, which matches the splitter's order, so split followed by pack is identity.
- Accept with cnt<DEPTH-1: write the slot, then cnt+1.
- Accept with cnt==DEPTH-1 (completing symbol):
  - obuf <= acc with the final slot merged; olen <= DEPTH; ofull <= 1.
  - cnt <= 0; acc <= 0.
- Space available: slot = ~ofull | i_ready.
- o_ready = i_start & ((cnt != DEPTH-1) | slot). This is a combinational path from i_ready to o_ready by design.
- Flush, when i_flush & i_start & slot:
  - The effective count n is cnt plus 1 if a symbol is accepted in the same cycle. That symbol is included in the flushed word.
  - If n>0: obuf <= acc with unused slots zero; olen <= n; ofull <= 1; cnt <= 0; acc <= 0.
  - If n==0: no action.
  - If the accepted symbol completes the word, the result is identical to a normal completion (olen=DEPTH).
- A flush requested while slot==0 is ignored. The requester holds i_flush until it takes effect.
- Output transfer: o_valid & i_ready clears ofull, unless a new word loads in the same cycle. A new word always has priority to reload.
- i_start low: acc and cnt clear next cycle; o_ready=0; the output register keeps draining normally.
- Reset priority: i_rst overrides everything else, including a handshake in the same cycle.

## Timing
- Reset values: o_valid=0, o_data=0, o_len=0, o_ready=0 during reset. After reset, cnt=0 and acc=0.
- Latency: a word is on o_valid the cycle after its completing (or flushing) accept.
- Throughput: one symbol per cycle sustained when i_ready=1. Back-to-back words have o_valid continuously high.
- Backpressure:
  - Holding: o_data and o_len are stable while o_valid & ~i_ready.
  - Stall point: with ofull=1 and i_ready=0, symbols 0..DEPTH-2 of the next word are still accepted. o_ready drops only when cnt==DEPTH-1.
- Simultaneous load and drain: ofull stays 1 and obuf takes the new word. There is no bubble.
- Reset mid-word: the partial word and any pending output are lost with no output pulse.

## Test plan
- Reset then sequential packing: with i_start=1 and i_ready=1, feed symbols 0,1,2,3,0,1,2,3 on consecutive cycles. Expect o_data=16'hE4E4, o_len=8, o_valid for exactly 1 cycle, 1 cycle after the 8th accept.
- Backpressure:
  - Stimulus: hold i_ready=0 after word A = 16'hFFFF (all symbols 3), then stream 8 more symbols.
  - Expect: 7 accepts, then o_ready=0 with A held stable.
  - On i_ready=1: A transfers, the 8th symbol is accepted in the same cycle, and word B appears the next cycle.
- Flush partial:
  - Feed symbols 1,2,3, then i_flush together with symbol 1 accepted.
  - Expect o_data=16'h0079, o_len=4.
  - A flush with cnt=0 and no accept produces no o_valid.
- Flush collision: i_flush on the cycle of the 8th symbol. Expect a single word with o_len=8 and no extra empty word.
- i_start drop: after 5 symbols, drop i_start for 1 cycle, then feed 8 symbols of value 2. Expect o_data=16'hAAAA; the earlier partial word is discarded.
- Mid-operation reset: assert i_rst while o_valid=1 and cnt=3.
  - Expect o_valid=0 and o_len=0 next cycle.
  - The next full word packs from slot 0.
